// File: rtl/mbist_march_ctrl.sv
// March C- self-test controller for one single-port synchronous RAM.
// Define MBIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module mbist_march_ctrl #(
    parameter int            AW     = 8,
    parameter int            DW     = 8,
    parameter logic [DW-1:0] BG     = DW'(8'h55),
    parameter int            RD_LAT = 1,
    parameter int            ECW    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [ECW-1:0] err_cnt,
    output logic [AW-1:0]  fail_addr,
    output logic [2:0]     fail_elem,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_wren,
    input  logic [DW-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RDWAIT,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    elem;
    logic [AW-1:0] addr;
    logic          phase;
    logic [1:0]    lat;

    logic down, is_wr, last_op, term, last_el;
    logic exp_one, wr_one, go, rd_end, miss, adv;

    // Elements 3 and 4 walk downward; element 0 is write-only, 5 read-only.
    assign down    = (elem == 3'd3) || (elem == 3'd4);
    assign is_wr   = (elem == 3'd0) || phase;
    assign last_op = (elem == 3'd0) || (elem == 3'd5) || phase;
    assign term    = down ? (addr == '0) : (addr == '1);
    assign last_el = (elem == 3'd5);
    assign exp_one = (elem == 3'd2) || (elem == 3'd4);
    assign wr_one  = (elem == 3'd1) || (elem == 3'd3);
    assign go      = start && (state == S_IDLE || state == S_DONE);
    assign rd_end  = (state == S_RDWAIT) && (lat == 2'(RD_LAT - 1));
    assign miss    = rd_end && (mem_rdata != (exp_one ? ~BG : BG));

    assign busy      = (state == S_RUN) || (state == S_RDWAIT);
    assign done      = (state == S_DONE);
    assign mem_wren  = (state == S_RUN) && is_wr;
    assign mem_addr  = addr;
    assign mem_wdata = (busy && wr_one) ? ~BG : BG;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                if (is_wr) adv      = 1'b1;
                else       state_nx = S_RDWAIT;
            end
            S_RDWAIT: begin
                if (rd_end) begin
                    adv      = 1'b1;
                    state_nx = (last_el && term && last_op) ? S_DONE : S_RUN;
`ifdef MBIST_STOP_ON_FAIL_EN
                    if (miss) state_nx = S_DONE;
`endif
                end
            end
            S_DONE: if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            lat       <= '0;
            pass      <= 1'b1;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (go) begin
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            lat       <= '0;
            pass      <= 1'b1;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            if (state == S_RUN)         lat <= '0;
            else if (state == S_RDWAIT) lat <= lat + 2'd1;
            if (adv) begin
                if (!last_op) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (!term) begin
                        addr <= down ? addr - 1'b1 : addr + 1'b1;
                    end else if (!last_el) begin
                        elem <= elem + 3'd1;
                        // Entering element 3 or 4 starts at the top address.
                        addr <= (elem == 3'd2 || elem == 3'd3) ? '1 : '0;
                    end
                end
            end
            if (miss) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                pass <= 1'b0;
                if (pass) begin
                    fail_addr <= addr;
                    fail_elem <= elem;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: a March C- model predicts the
// per-cycle RAM bus trace and the run result for a RAM with one stuck bit.
module tb_mbist_march_ctrl;

    localparam int            AW     = 3;
    localparam int            DW     = 8;
    localparam int            RD_LAT = 2;
    localparam int            ECW    = 8;
    localparam int            N      = 1 << AW;
    localparam logic [DW-1:0] BG     = 8'h55;
`ifdef MBIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, pass, mem_wren;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  fail_addr, mem_addr;
    logic [2:0]     fail_elem;
    logic [DW-1:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .AW(AW), .DW(DW), .BG(BG), .RD_LAT(RD_LAT), .ECW(ECW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_addr(fail_addr), .fail_elem(fail_elem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata)
    );

    // RAM with one optional stuck-at bit and RD_LAT clocks of read latency.
    bit            f_en;
    int            f_addr, f_bit;
    bit            f_val;
    logic [DW-1:0] ram  [N];
    logic [DW-1:0] pipe [RD_LAT];

    function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        pipe[0] <= rd_fault(ram[mem_addr], int'(mem_addr));
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    typedef struct { bit wr; int addr; int wdata; } bus_t;
    typedef struct { int cyc; bit pass; int err; int fa; int fe; } res_t;

    bus_t bus_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Reference: walk the March C- elements over an array memory.
    logic [DW-1:0] mm [N];

    task automatic model(output int cyc);
        res_t          r;
        bit            stop;
        int            a;
        logic [DW-1:0] rv, ev;
        r    = '{0, 1'b1, 0, 0, 0};
        stop = 1'b0;
        for (int e = 0; e < 6 && !stop; e++) begin
            for (int k = 0; k < N && !stop; k++) begin
                a = (e == 3 || e == 4) ? N - 1 - k : k;
                if (e > 0) begin
                    ev = (e == 2 || e == 4) ? ~BG : BG;
                    for (int j = 0; j <= RD_LAT; j++) bus_q.push_back('{1'b0, a, 0});
                    r.cyc += 1 + RD_LAT;
                    rv = mm[a];
                    if (f_en && a == f_addr) rv[f_bit] = f_val;
                    if (rv != ev) begin
                        if (r.pass) begin
                            r.fa = a;
                            r.fe = e;
                        end
                        r.pass = 1'b0;
                        if (r.err < (1 << ECW) - 1) r.err++;
                        if (STOP) stop = 1'b1;
                    end
                end
                if (e < 5 && !stop) begin
                    ev = (e == 1 || e == 3) ? ~BG : BG;
                    bus_q.push_back('{1'b1, a, int'(ev)});
                    r.cyc++;
                    mm[a] = ev;
                end
            end
        end
        res_q.push_back(r);
        cyc = r.cyc;
    endtask

    // Monitor: checks the bus every busy cycle and the result at done.
    int   bcnt = 0;
    logic busy_q = 1'b0;
    logic done_q = 1'b0;

    always @(negedge clk) begin
        bus_t b;
        res_t r;
        if (busy) begin
            if (!busy_q) bcnt = 0;
            bcnt++;
            if (bus_q.size() == 0) begin
                chk("bus_extra_cycle", 1, 0);
            end else begin
                b = bus_q.pop_front();
                chk("mem_wren", int'(mem_wren), int'(b.wr));
                chk("mem_addr", int'(mem_addr), b.addr);
                if (b.wr) chk("mem_wdata", int'(mem_wdata), b.wdata);
            end
        end else begin
            chk("idle_wren", int'(mem_wren), 0);
        end
        if (done && !done_q) begin
            if (res_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                r = res_q.pop_front();
                chk("busy_cycles", bcnt, r.cyc);
                chk("busy_at_done", int'(busy), 0);
                chk("pass", int'(pass), int'(r.pass));
                chk("err_cnt", int'(err_cnt), r.err);
                chk("fail_addr", int'(fail_addr), r.fa);
                chk("fail_elem", int'(fail_elem), r.fe);
                chk("bus_left", bus_q.size(), 0);
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 1);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_fail_addr", int'(fail_addr), 0);
        chk("rst_fail_elem", int'(fail_elem), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), int'(BG));
        chk("rst_mem_wren", int'(mem_wren), 0);
    endtask

    task automatic run(input bit en, input int fa, input int fb,
                       input bit fv, input int extra);
        int cyc, i;
        int p[3];
        f_en   = en;
        f_addr = fa;
        f_bit  = fb;
        f_val  = fv;
        model(cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done", int'(done), 0);
        chk("start_pass", int'(pass), 1);
        chk("start_err_cnt", int'(err_cnt), 0);
        for (int s = 0; s < 3; s++)
            p[s] = (s < extra && cyc > 6) ? int'($urandom_range(1, cyc - 3)) : -1;
        i = 0;
        while (res_q.size() != 0 && i < 5000) begin
            i++;
            if (i == p[0] || i == p[1] || i == p[2]) start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (res_q.size() != 0) begin
            chk("done_timeout", 1, 0);
            res_q.delete();
            bus_q.delete();
        end
        tick(2);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        tick(3);
        check_reset();
        reset = 1'b1;
        tick(2);

        run(1'b0, 0, 0, 1'b0, 0);
        run(1'b1, 2, 0, 1'b1, 2);
        run(1'b0, 0, 0, 1'b0, 1);
        repeat (8)
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                int'($urandom_range(0, DW - 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));

        f_en = 1'b0;
        model(cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(19);
        reset = 1'b0;
        tick();
        bus_q.delete();
        res_q.delete();
        check_reset();
        reset = 1'b1;
        tick(2);
        run(1'b0, 0, 0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
